ez8_fetch_seq: RTL and testbench

//  Parametrised successor to the ez8 program-counter controller: generates the

---
 rtl/ez8_fetch_seq.sv | 81 ++++++++
 tb/tb_ez8_fetch_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ez8_fetch_seq.sv
// Fetch-address sequencer for the ez8 core: PC, pipeline kill, and a hardware
// return stack for call/ret, plus goto and skip-next, against 1-clk instr_mem.
module ez8_fetch_seq #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    localparam int                   DW          = $clog2(STACK_DEPTH + 1),
    localparam int                   IW          = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  goto,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  skip,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  kill,
    output logic [DW-1:0]         stack_depth,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic          accept;
    logic          do_ret, do_call, do_goto, do_redirect_or_skip;
    logic          stack_full, stack_empty;
    logic [DW-1:0] depth_dec;
    logic [IW-1:0] push_idx, top_idx;

    // Decode inputs only count when the slot at decode is a real instruction.
    assign accept  = !pause && !kill;
    assign do_ret  = accept && ret;
    assign do_call = accept && call && !ret;
    assign do_goto = accept && goto && !ret && !call;
    assign do_redirect_or_skip = accept && (ret || call || goto || skip);

    assign stack_full  = (stack_depth == DW'(STACK_DEPTH));
    assign stack_empty = (stack_depth == '0);
    assign depth_dec   = stack_depth - 1'b1;
    assign push_idx    = stack_depth[IW-1:0];
    assign top_idx     = depth_dec[IW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out          <= RESET_ADDR;
            kill            <= 1'b1;
            stack_depth     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else if (!pause) begin
            kill <= do_redirect_or_skip;
            if (do_ret) begin
                if (stack_empty) begin
                    pc_out          <= RESET_ADDR;
                    stack_underflow <= 1'b1;
                end else begin
                    pc_out      <= stack_mem[top_idx];
                    stack_depth <= depth_dec;
                end
            end else if (do_call) begin
                pc_out <= target;
                // Full stack: the jump still happens, the return address is dropped.
                if (stack_full) begin
                    stack_overflow <= 1'b1;
                end else begin
                    stack_mem[push_idx] <= pc_out;
                    stack_depth         <= stack_depth + 1'b1;
                end
            end else if (do_goto) begin
                pc_out <= target;
            end else begin
                pc_out <= pc_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ez8_fetch_seq.sv
// Directed bench for ez8_fetch_seq: a 12-bit/8-deep instance for the main
// sequences and a 4-bit/2-deep instance for wrap, underflow and async reset.
module tb_ez8_fetch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst, pause, go, cl, rt, sk;
    logic [11:0] tgt, pc;
    logic        kill, ovf, udf;
    logic [3:0]  depth;

    // small instance
    logic       s_rst, s_pause, s_go, s_cl, s_rt, s_sk;
    logic [3:0] s_tgt, s_pc;
    logic       s_kill, s_ovf, s_udf;
    logic [1:0] s_depth;

    int ntests = 0;
    int nfail  = 0;

    ez8_fetch_seq #(.ADDR_WIDTH(12), .STACK_DEPTH(8), .RESET_ADDR(12'h000)) dut (
        .clk(clk), .reset(rst), .pause(pause), .goto(go), .call(cl), .ret(rt),
        .skip(sk), .target(tgt), .pc_out(pc), .kill(kill), .stack_depth(depth),
        .stack_overflow(ovf), .stack_underflow(udf)
    );

    ez8_fetch_seq #(.ADDR_WIDTH(4), .STACK_DEPTH(2), .RESET_ADDR(4'h3)) dut_s (
        .clk(clk), .reset(s_rst), .pause(s_pause), .goto(s_go), .call(s_cl), .ret(s_rt),
        .skip(s_sk), .target(s_tgt), .pc_out(s_pc), .kill(s_kill), .stack_depth(s_depth),
        .stack_overflow(s_ovf), .stack_underflow(s_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [11:0] epc, input logic ekill,
                            input logic [3:0] edep);
        chk({tag, ".pc"}, 32'(pc), 32'(epc));
        chk({tag, ".kill"}, 32'(kill), 32'(ekill));
        chk({tag, ".depth"}, 32'(depth), 32'(edep));
    endtask

    logic [11:0] pushed [1:9];
    logic [11:0] cur, t;

    initial begin
        rst = 1'b1; pause = 0; go = 0; cl = 0; rt = 0; sk = 0; tgt = '0;
        s_rst = 1'b1; s_pause = 0; s_go = 0; s_cl = 0; s_rt = 0; s_sk = 0; s_tgt = '0;
        step(); step();

        // 1: reset state and free running
        chk_main("rst", 12'h000, 1'b1, 4'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.udf", 32'(udf), 32'd0);
        rst = 1'b0;
        chk_main("free0", 12'h000, 1'b1, 4'd0);
        step(); chk_main("free1", 12'h001, 1'b0, 4'd0);
        step(); chk_main("free2", 12'h002, 1'b0, 4'd0);
        step(); chk_main("free3", 12'h003, 1'b0, 4'd0);

        // 2: goto, and goto during kill ignored
        step(); step();
        chk_main("pre_goto", 12'h005, 1'b0, 4'd0);
        go = 1; tgt = 12'h100;
        step();
        chk_main("goto", 12'h100, 1'b1, 4'd0);
        tgt = 12'h300;
        step(); go = 0;
        chk_main("goto_in_kill", 12'h101, 1'b0, 4'd0);

        // 3: call / ret
        go = 1; tgt = 12'h010; step(); go = 0;
        step();
        chk_main("pre_call", 12'h011, 1'b0, 4'd0);
        cl = 1; tgt = 12'h200; step(); cl = 0;
        chk_main("call", 12'h200, 1'b1, 4'd1);
        step();
        chk_main("call_body", 12'h201, 1'b0, 4'd1);
        rt = 1; step(); rt = 0;
        chk_main("ret", 12'h011, 1'b1, 4'd0);
        step();
        chk_main("post_ret", 12'h012, 1'b0, 4'd0);

        // 4: nine nested calls, overflow, LIFO rets, underflow
        cur = 12'h012;
        for (int k = 1; k <= 9; k++) begin
            t = 12'h400 + 12'(16 * (k - 1));
            pushed[k] = cur;
            cl = 1; tgt = t; step(); cl = 0;
            chk_main($sformatf("ncall%0d", k), t, 1'b1, (k > 8) ? 4'd8 : 4'(k));
            chk($sformatf("ncall%0d.ovf", k), 32'(ovf), (k == 9) ? 32'd1 : 32'd0);
            step();
            cur = t + 12'h001;
            chk($sformatf("ncall%0d.pc1", k), 32'(pc), 32'(cur));
        end
        for (int j = 1; j <= 8; j++) begin
            rt = 1; step(); rt = 0;
            chk_main($sformatf("nret%0d", j), pushed[9 - j], 1'b1, 4'(8 - j));
            step();
        end
        rt = 1; step(); rt = 0;
        chk_main("uflow", 12'h000, 1'b1, 4'd0);
        chk("uflow.udf", 32'(udf), 32'd1);
        chk("uflow.ovf_sticky", 32'(ovf), 32'd1);

        // 5: skip, then pause with a goto that must be lost
        step();
        go = 1; tgt = 12'h01F; step(); go = 0;
        step();
        chk_main("pre_skip", 12'h020, 1'b0, 4'd0);
        sk = 1; step(); sk = 0;
        chk_main("skip", 12'h021, 1'b1, 4'd0);
        step();
        chk_main("post_skip", 12'h022, 1'b0, 4'd0);
        pause = 1; go = 1; tgt = 12'h333;
        for (int p = 0; p < 3; p++) begin
            step();
            chk_main($sformatf("pause%0d", p), 12'h022, 1'b0, 4'd0);
        end
        pause = 0; go = 0;
        step();
        chk_main("unpause", 12'h023, 1'b0, 4'd0);
        chk("unpause.udf", 32'(udf), 32'd1);

        // 6: narrow instance: RESET_ADDR, underflow, wrap, async reset mid-call
        s_rst = 1'b0;
        chk("s.rst_pc", 32'(s_pc), 32'h3);
        chk("s.rst_kill", 32'(s_kill), 32'd1);
        step();
        chk("s.pc4", 32'(s_pc), 32'h4);
        s_rt = 1; step(); s_rt = 0;
        chk("s.uflow_pc", 32'(s_pc), 32'h3);
        chk("s.uflow_flag", 32'(s_udf), 32'd1);
        chk("s.uflow_kill", 32'(s_kill), 32'd1);
        step();
        s_go = 1; s_tgt = 4'hE; step(); s_go = 0;
        chk("s.pcE", 32'(s_pc), 32'hE);
        step(); chk("s.pcF", 32'(s_pc), 32'hF);
        step(); chk("s.wrap", 32'(s_pc), 32'h0);
        chk("s.wrap_kill", 32'(s_kill), 32'd0);
        s_cl = 1; s_tgt = 4'h5; step(); s_cl = 0;
        chk("s.call_pc", 32'(s_pc), 32'h5);
        chk("s.call_depth", 32'(s_depth), 32'd1);
        step();
        s_cl = 1; s_tgt = 4'h9;
        #2 s_rst = 1'b1;
        #1;
        chk("s.arst_pc", 32'(s_pc), 32'h3);
        chk("s.arst_depth", 32'(s_depth), 32'd0);
        chk("s.arst_kill", 32'(s_kill), 32'd1);
        chk("s.arst_udf", 32'(s_udf), 32'd0);
        s_cl = 0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
